// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] COM_OFF   = 4'b1111;

  typedef enum logic {GAP, DRIVE} state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Shadow digits load only at the frame boundary so a frame never shows mixed values.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned GAP_CYC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_update,
  input  logic [3:0] i_digit_1,
  input  logic [3:0] i_digit_10,
  input  logic [3:0] i_digit_100,
  input  logic [3:0] i_digit_1000,
  input  logic [3:0] i_dp,
  input  logic       i_lz_en,
  output logic [1:0] o_sel,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_data,
  output logic       o_frame_tick
);

  localparam int unsigned DIGIT_CYC = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW        = $clog2(DIGIT_CYC);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] CNT_GAP_END = CW'(GAP_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    dp_q, dp_d;
  logic          lz_q, lz_d;
  logic          pend_q, pend_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;
  logic          tick_q, tick_d;

  logic          last;
  logic          boundary;
  logic [3:0]    cur_digit;
  logic          blank;
  logic [6:0]    seg;

  bcd_to_seg u_dec (
    .digit(cur_digit),
    .seg  (seg)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dig_d    = dig_q;
    dp_d     = dp_q;
    lz_d     = lz_q;
    pend_d   = pend_q;

    last     = (cnt_q == CNT_LAST);
    boundary = last && (sel_q == 2'd3);
    cnt_d    = last ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      GAP:   if (cnt_q == CNT_GAP_END) state_d = DRIVE;
      DRIVE: if (last) begin
        state_d = GAP;
        sel_d   = sel_q + 2'd1;
      end
    endcase

    // A pulse on the boundary cycle itself loads directly without touching pending.
    if (boundary && (pend_q || i_update)) begin
      dig_d  = {i_digit_1000, i_digit_100, i_digit_10, i_digit_1};
      dp_d   = i_dp;
      lz_d   = i_lz_en;
      pend_d = 1'b0;
    end else if (i_update) begin
      pend_d = 1'b1;
    end

    // Outputs are computed from next state so registered pins line up with the counter.
    cur_digit = dig_q[3:0];
    blank     = 1'b0;
    unique case (sel_d)
      2'd0: cur_digit = dig_q[3:0];
      2'd1: begin
        cur_digit = dig_q[7:4];
        blank     = lz_q && (dig_q[15:4] == 12'h000);
      end
      2'd2: begin
        cur_digit = dig_q[11:8];
        blank     = lz_q && (dig_q[15:8] == 8'h00);
      end
      2'd3: begin
        cur_digit = dig_q[15:12];
        blank     = lz_q && (dig_q[15:12] == 4'h0);
      end
    endcase

    tick_d = (cnt_d == CNT_LAST) && (sel_d == 2'd3);
    if (state_d == GAP) begin
      com_d  = COM_OFF;
      data_d = 8'hFF;
    end else begin
      com_d  = ~(4'b0001 << sel_d);
      data_d = {~dp_q[sel_d], blank ? SEG_BLANK : seg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GAP;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      dig_q   <= 16'h0000;
      dp_q    <= 4'h0;
      lz_q    <= 1'b0;
      pend_q  <= 1'b0;
      com_q   <= COM_OFF;
      data_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      lz_q    <= lz_d;
      pend_q  <= pend_d;
      com_q   <= com_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
    end
  end

  assign o_sel        = sel_q;
  assign o_fnd_com    = com_q;
  assign o_fnd_data   = data_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench: a frame-arithmetic model pushes per-cycle expected pins, a monitor compares.
module tb_fnd_scan_ctrl;

  localparam int unsigned DC  = 10;
  localparam int unsigned GAP = 2;
  localparam int unsigned FR  = 4 * DC;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] com;
    logic [7:0] data;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_update = 1'b0;
  logic [3:0] i_digit_1 = 4'h0, i_digit_10 = 4'h0, i_digit_100 = 4'h0, i_digit_1000 = 4'h0;
  logic [3:0] i_dp = 4'h0;
  logic       i_lz_en = 1'b0;
  logic [1:0] o_sel;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_data;
  logic       o_frame_tick;

  int checks = 0;
  int errors = 0;
  int n_mon  = 0;

  exp_t        q[$];
  int unsigned t;
  logic [3:0]  m_dig[4];
  logic [3:0]  m_dp;
  logic        m_lz;
  logic        m_pend;

  logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  fnd_scan_ctrl #(
    .CLK_HZ (1000),
    .SCAN_HZ(100),
    .GAP_CYC(GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_update    (i_update),
    .i_digit_1   (i_digit_1),
    .i_digit_10  (i_digit_10),
    .i_digit_100 (i_digit_100),
    .i_digit_1000(i_digit_1000),
    .i_dp        (i_dp),
    .i_lz_en     (i_lz_en),
    .o_sel       (o_sel),
    .o_fnd_com   (o_fnd_com),
    .o_fnd_data  (o_fnd_data),
    .o_frame_tick(o_frame_tick)
  );

  always #5 clk = ~clk;

  function automatic exp_t expect_at(int unsigned tt);
    exp_t        e;
    int unsigned s, off;
    logic        blank;
    logic [7:0]  pat;
    s      = (tt / DC) % 4;
    off    = tt % DC;
    e.sel  = 2'(s);
    e.tick = (off == DC - 1) && (s == 3);
    e.com  = 4'hF;
    e.data = 8'hFF;
    if (off >= GAP) begin
      e.com[s] = 1'b0;
      blank = m_lz && (s > 0);
      for (int k = s; k < 4; k++) if (m_dig[k] != 4'h0) blank = 1'b0;
      pat = seg_tab[m_dig[s]];
      e.data = {~m_dp[s], blank ? 7'h7F : pat[6:0]};
    end
    return e;
  endfunction

  // Reference model: t counts clocks since reset release; frame position is plain arithmetic.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      t = 0;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
      m_dp = 4'h0;
      m_lz = 1'b0;
      m_pend = 1'b0;
      q.delete();
      q.push_back(expect_at(0));
    end else begin
      if ((t % FR == FR - 1) && (m_pend || i_update)) begin
        m_dig[0] = i_digit_1;
        m_dig[1] = i_digit_10;
        m_dig[2] = i_digit_100;
        m_dig[3] = i_digit_1000;
        m_dp = i_dp;
        m_lz = i_lz_en;
        m_pend = 1'b0;
      end else if (i_update) begin
        m_pend = 1'b1;
      end
      t++;
      q.push_back(expect_at(t));
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      n_mon++;
      checks++;
      if ({o_sel, o_fnd_com, o_fnd_data, o_frame_tick} !== e) begin
        errors++;
        $display("FAIL pins t=%0d: got sel=%0d com=%b data=%h tick=%b, want sel=%0d com=%b data=%h tick=%b",
                 t, o_sel, o_fnd_com, o_fnd_data, o_frame_tick, e.sel, e.com, e.data, e.tick);
      end
    end
  end

  task automatic check_reset_pins(input string name);
    checks++;
    if (o_sel !== 2'd0 || o_fnd_com !== 4'hF || o_fnd_data !== 8'hFF || o_frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s: got sel=%0d com=%b data=%h tick=%b, want sel=0 com=1111 data=ff tick=0",
               name, o_sel, o_fnd_com, o_fnd_data, o_frame_tick);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    i_update = 1'b1;
    @(negedge clk);
    i_update = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input logic [3:0] dp, input logic lz);
    i_digit_1000 = d3;
    i_digit_100  = d2;
    i_digit_10   = d1;
    i_digit_1    = d0;
    i_dp         = dp;
    i_lz_en      = lz;
  endtask

  task automatic wait_pos(input int unsigned pos, input string name);
    int n;
    n = 0;
    while ((t % FR) != pos && n < 2 * FR) begin
      @(negedge clk);
      n++;
    end
    if ((t % FR) != pos) begin
      checks++;
      errors++;
      $display("FAIL %s: frame position %0d not reached, at %0d", name, pos, t % FR);
    end
  endtask

  initial begin
    reset = 1'b1;
    #1;
    check_reset_pins("reset_state");
    cyc(3);
    #2 reset = 1'b0;
    cyc(100);

    set_in(4'd4, 4'd3, 4'd2, 4'd1, 4'h0, 1'b0);
    wait_pos(15, "mid_frame");
    pulse();
    cyc(90);

    set_in(4'd0, 4'd0, 4'd4, 4'd2, 4'b0010, 1'b1);
    pulse();
    cyc(90);

    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b1);
    pulse();
    pulse();
    cyc(90);

    set_in(4'd8, 4'd8, 4'd8, 4'd8, 4'h0, 1'b0);
    wait_pos(FR - 1, "boundary");
    pulse();
    cyc(20);
    pulse();
    cyc(70);

    for (int it = 0; it < 30; it++) begin
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        set_in(4'h0, 4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'b1);
      end
      repeat ($urandom_range(1, 3)) begin
        cyc($urandom_range(0, 12));
        pulse();
      end
      cyc($urandom_range(10, 60));
    end

    // Reset during sel2 drive with a load pending; the pending request must be lost.
    set_in(4'd7, 4'd6, 4'd5, 4'd9, 4'hF, 1'b0);
    wait_pos(20, "pre_reset");
    pulse();
    wait_pos(25, "sel2_drive");
    #2 reset = 1'b1;
    #1;
    check_reset_pins("reset_mid_frame");
    cyc(2);
    #2 reset = 1'b0;
    cyc(100);

    checks++;
    if (n_mon < 1000) begin
      errors++;
      $display("FAIL monitor_count: got %0d samples, want at least 1000", n_mon);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
